// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//  Types shared by the memory bus arbiter and its neighbours.
//  arb_state_t : arbiter FSM states
//  arb_idx_t   : requester index for the default two-core build
//                (index r = 2*cpu + 1 for D$, + 0 for I$)
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int ARB_NCPU = 2;
    localparam int ARB_NREQ = 2 * ARB_NCPU;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        COOL
    } arb_state_t;

    typedef logic [$clog2(ARB_NREQ)-1:0] arb_idx_t;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//  Combinational round-robin picker. Scans ptr+1, ptr+2, ... (mod N) and
//  returns the first requester found, so the last winner (ptr) is checked last.
//  Ports:
//   req  in   N      request vector
//   ptr  in   IW     index of the previous winner
//   win  out  IW     selected requester (0 when none)
//   any  out  1      at least one request pending
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any
);

    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx[IW-1:0]]) begin
                win   = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//  Shares the coherence/memory controller between the I$ and D$ ports of all
//  cores. Round-robin pick in IDLE, registered grant held until the controller
//  pulses done, then one dead COOL cycle so the finished requester can drop.
//  Optional starvation guard: define ARB_STARVE_GUARD_EN to add per-requester
//  age counters; a requester that has waited AGE_MAX cycles beats the
//  round-robin order (lowest index among several).
//  Ports:
//   CLK        in   1             clock, rising edge
//   nRST       in   1             async active-low reset
//   ireq       in   NCPU          I$ request per core
//   dreq       in   NCPU          D$ request per core
//   done       in   1             granted transaction finished (BUSY only)
//   gnt_valid  out  1             grant active
//   gnt_cpu    out  clog2(NCPU)   core owning the grant
//   gnt_d      out  1             1 = D$ grant, 0 = I$ grant
//   gnt_vec    out  2*NCPU        one-hot grant (zero when idle)
//   busy       out  1             high in GRANT/BUSY/COOL
// ----------------------------------------------------------------------------
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCPU    = 2,
    parameter int AGE_MAX = 15
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCPU-1:0]         ireq,
    input  logic [NCPU-1:0]         dreq,
    input  logic                    done,
    output logic                    gnt_valid,
    output logic [$clog2(NCPU)-1:0] gnt_cpu,
    output logic                    gnt_d,
    output logic [2*NCPU-1:0]       gnt_vec,
    output logic                    busy
);

    localparam int NREQ = 2 * NCPU;
    localparam int IW   = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef logic [IW-1:0] idx_t;

    if (AGE_MAX < 1) begin : g_age_chk
        $error("AGE_MAX must be at least 1");
    end

    arb_state_t      state;
    idx_t            ptr;
    idx_t            win_q;
    idx_t            rr_win;
    idx_t            pick;
    logic [NREQ-1:0] req;
    logic            any;

    // Interleave per core: even index I$, odd index D$.
    always_comb begin
        req = '0;
        for (int c = 0; c < NCPU; c++) begin
            req[2*c]   = ireq[c];
            req[2*c+1] = dreq[c];
        end
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .win (rr_win),
        .any (any)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

    logic [NREQ-1:0][AW-1:0] age;

    // Age counts cycles spent requesting without holding the grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            age <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r] || gnt_vec[r])
                    age[r] <= '0;
                else if (age[r] != AGE_SAT)
                    age[r] <= age[r] + 1'b1;
            end
        end
    end

    // Descending scan so the lowest saturated index ends up selected.
    always_comb begin
        pick = rr_win;
        for (int r = NREQ - 1; r >= 0; r--) begin
            if (req[r] && (age[r] == AGE_SAT))
                pick = idx_t'(r);
        end
    end
`else
    assign pick = rr_win;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ptr       <= '0;
            win_q     <= '0;
            gnt_valid <= 1'b0;
            gnt_cpu   <= '0;
            gnt_d     <= 1'b0;
            gnt_vec   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state     <= GRANT;
                        win_q     <= pick;
                        gnt_valid <= 1'b1;
                        gnt_cpu   <= pick[IW-1:1];
                        gnt_d     <= pick[0];
                        gnt_vec   <= ONE << pick;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    // Winner drops to lowest priority for the next round.
                    ptr   <= win_q;
                    state <= BUSY;
                end
                BUSY: begin
                    // done takes precedence over a simultaneous request drop.
                    if (done || !req[win_q]) begin
                        state     <= done ? COOL : IDLE;
                        gnt_valid <= 1'b0;
                        gnt_cpu   <= '0;
                        gnt_d     <= 1'b0;
                        gnt_vec   <= '0;
                        busy      <= done;
                    end
                end
                COOL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                    gnt_cpu   <= '0;
                    gnt_d     <= 1'b0;
                    gnt_vec   <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
